// File: rtl/qpsk_pkg.sv
// ---------------------------------------------------------------------------
// qpsk_pkg
// Shared types for the QPSK symbol sequencer:
//   fsm_state_t  - output FSM (idle / holding a symbol)
//   coll_state_t - dibit collector (no half pair / I bit captured)
//   SPS_W_DEF    - default width of the samples-per-symbol input
// ---------------------------------------------------------------------------
package qpsk_pkg;

  localparam int SPS_W_DEF = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } fsm_state_t;

  typedef enum logic {
    C_EMPTY = 1'b0,
    C_HALF  = 1'b1
  } coll_state_t;

endpackage : qpsk_pkg

// File: rtl/qpsk_dibit_collector.sv
// ---------------------------------------------------------------------------
// qpsk_dibit_collector
// Pairs a serial bit stream into dibits. The first bit of a pair is parked in
// a half register (I), the second completes the pair into the pending
// register (I,Q) which the output FSM consumes on a load.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   i_enable   in   allows new bits to be accepted
//   i_flush    in   synchronous clear of half and pending registers
//   i_data     in   serial data bit
//   i_valid    in   i_data is valid
//   i_consume  in   output FSM is loading the pending pair this cycle
//   o_ready    out  bit accepted this cycle when i_valid is high
//   o_pend_full out pending pair present
//   o_pend_i   out  pending in-phase bit
//   o_pend_q   out  pending quadrature bit
// ---------------------------------------------------------------------------
module qpsk_dibit_collector
  import qpsk_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_flush,
  input  logic i_data,
  input  logic i_valid,
  input  logic i_consume,
  output logic o_ready,
  output logic o_pend_full,
  output logic o_pend_i,
  output logic o_pend_q
);

  coll_state_t r_state, w_state_nxt;
  logic        r_half_i, w_half_i_nxt;
  logic        r_pend_i, w_pend_i_nxt;
  logic        r_pend_q, w_pend_q_nxt;
  logic        r_pend_full, w_pend_full_nxt;
  logic        w_half_full;
  logic        w_accept;

  assign w_half_full = (r_state == C_HALF);

  // An I bit may still be taken while a full pair waits; only a second
  // pending pair has nowhere to go.
  assign o_ready  = i_enable & ~i_flush & ~(r_pend_full & w_half_full);
  assign w_accept = i_valid & o_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= C_EMPTY;
      r_half_i    <= 1'b0;
      r_pend_i    <= 1'b0;
      r_pend_q    <= 1'b0;
      r_pend_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_half_i    <= w_half_i_nxt;
      r_pend_i    <= w_pend_i_nxt;
      r_pend_q    <= w_pend_q_nxt;
      r_pend_full <= w_pend_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_half_i_nxt    = r_half_i;
    w_pend_i_nxt    = r_pend_i;
    w_pend_q_nxt    = r_pend_q;
    w_pend_full_nxt = r_pend_full;

    // A consume reads the pending pair this cycle, so clearing it here is
    // also what lets a load win over a simultaneous flush.
    if (i_consume) begin
      w_pend_full_nxt = 1'b0;
    end

    if (i_flush) begin
      w_state_nxt     = C_EMPTY;
      w_pend_full_nxt = 1'b0;
    end else if (w_accept) begin
      case (r_state)
        C_EMPTY: begin
          w_half_i_nxt = i_data;
          w_state_nxt  = C_HALF;
        end
        C_HALF: begin
          // Only reachable with the pending register free (see o_ready).
          w_pend_i_nxt    = r_half_i;
          w_pend_q_nxt    = i_data;
          w_pend_full_nxt = 1'b1;
          w_state_nxt     = C_EMPTY;
        end
        default: w_state_nxt = C_EMPTY;
      endcase
    end
  end

  assign o_pend_full = r_pend_full;
  assign o_pend_i    = r_pend_i;
  assign o_pend_q    = r_pend_q;

endmodule : qpsk_dibit_collector

// File: rtl/qpsk_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// qpsk_symbol_sequencer
// Symbol-rate source for the QPSK bit splitter. Collects serial bits into
// I/Q dibits and holds each symbol for max(sps,1) clock cycles, pulsing
// sym_strobe at every symbol start and underrun when a symbol ends with no
// dibit ready.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   allows new bits to be accepted
//   flush       in   synchronous clear of buffered, not-yet-output bits
//   sps         in   clock cycles per symbol (0 behaves as 1)
//   bit_in      in   serial data bit
//   bit_valid   in   bit_in is valid
//   bit_ready   out  bit_in accepted this cycle when bit_valid is high
//   i_bit       out  in-phase bit of the current symbol
//   q_bit       out  quadrature bit of the current symbol
//   sym_strobe  out  one-cycle pulse with each new i_bit/q_bit
//   sym_active  out  a symbol is being held
//   underrun    out  one-cycle pulse when a symbol ends with nothing pending
// ---------------------------------------------------------------------------
module qpsk_symbol_sequencer
  import qpsk_pkg::*;
#(
  parameter int SPS_W = SPS_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [SPS_W-1:0] sps,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             i_bit,
  output logic             q_bit,
  output logic             sym_strobe,
  output logic             sym_active,
  output logic             underrun
);

  // Hold count reload value: max(s,1)-1, so the symbol lasts max(s,1) cycles.
  function automatic logic [SPS_W-1:0] hold_reload(input logic [SPS_W-1:0] s);
    return (s == '0) ? '0 : (s - SPS_W'(1));
  endfunction

  logic             w_pend_full;
  logic             w_pend_i;
  logic             w_pend_q;
  logic             w_load;

  fsm_state_t       r_state, w_state_nxt;
  logic [SPS_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_i_bit, w_i_bit_nxt;
  logic             r_q_bit, w_q_bit_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             r_active, w_active_nxt;
  logic             r_underrun, w_underrun_nxt;

  qpsk_dibit_collector u_collector (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_enable    (enable),
    .i_flush     (flush),
    .i_data      (bit_in),
    .i_valid     (bit_valid),
    .i_consume   (w_load),
    .o_ready     (bit_ready),
    .o_pend_full (w_pend_full),
    .o_pend_i    (w_pend_i),
    .o_pend_q    (w_pend_q)
  );

  // A new symbol starts either from idle or exactly as the current one ends.
  assign w_load = w_pend_full &
                  ((r_state == S_IDLE) || ((r_state == S_HOLD) && (r_cnt == '0)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_i_bit    <= 1'b0;
      r_q_bit    <= 1'b0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_i_bit    <= w_i_bit_nxt;
      r_q_bit    <= w_q_bit_nxt;
      r_strobe   <= w_strobe_nxt;
      r_active   <= w_active_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_i_bit_nxt    = r_i_bit;
    w_q_bit_nxt    = r_q_bit;
    w_active_nxt   = r_active;
    w_strobe_nxt   = 1'b0;
    w_underrun_nxt = 1'b0;

    if (w_load) begin
      // sps is sampled only here, so a mid-symbol change waits a symbol.
      w_i_bit_nxt  = w_pend_i;
      w_q_bit_nxt  = w_pend_q;
      w_strobe_nxt = 1'b1;
      w_active_nxt = 1'b1;
      w_cnt_nxt    = hold_reload(sps);
      w_state_nxt  = S_HOLD;
    end else if (r_state == S_HOLD) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - SPS_W'(1);
      end else begin
        w_underrun_nxt = 1'b1;
        w_i_bit_nxt    = 1'b0;
        w_q_bit_nxt    = 1'b0;
        w_active_nxt   = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    end
  end

  assign i_bit      = r_i_bit;
  assign q_bit      = r_q_bit;
  assign sym_strobe = r_strobe;
  assign sym_active = r_active;
  assign underrun   = r_underrun;

endmodule : qpsk_symbol_sequencer

// File: tb/tb_qpsk_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qpsk_symbol_sequencer
// Directed vectors for the QPSK symbol sequencer. Each streaming scenario
// gives the bit sequence plus per-cycle bitmasks (bit c = cycle c) of the
// expected bit_ready, sym_strobe and underrun values; the k-th strobe must
// carry bits 2k (I) and 2k+1 (Q) of the sequence.
// ---------------------------------------------------------------------------
module tb_qpsk_symbol_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       flush;
  logic [7:0] sps;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       i_bit;
  logic       q_bit;
  logic       sym_strobe;
  logic       sym_active;
  logic       underrun;

  int n_vec  = 0;
  int n_miss = 0;

  qpsk_symbol_sequencer #(.SPS_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .flush      (flush),
    .sps        (sps),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .i_bit      (i_bit),
    .q_bit      (q_bit),
    .sym_strobe (sym_strobe),
    .sym_active (sym_active),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Drives a bit stream honouring the handshake. Called #1 after a rising
  // edge; returns #1 after the last edge with bit_valid and flush low.
  task automatic run_stream(input string tag, input logic [7:0] sps_v, input int nb,
                            input logic [15:0] bits, input int ncyc,
                            input logic [31:0] rdy_m, input logic [31:0] stb_m,
                            input logic [31:0] und_m, input logic [31:0] fl_m);
    int   idx;
    int   k;
    logic took;
    idx = 0;
    k   = 0;
    sps = sps_v;
    for (int c = 1; c <= ncyc; c++) begin
      flush     = fl_m[c];
      bit_valid = (idx < nb);
      bit_in    = (idx < nb) ? bits[idx] : 1'b0;
      #1;
      if (idx < nb) check_eq($sformatf("%s_rdy_c%0d", tag, c), bit_ready, rdy_m[c]);
      took = bit_valid & bit_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
      check_eq($sformatf("%s_stb_c%0d", tag, c), sym_strobe, stb_m[c]);
      check_eq($sformatf("%s_und_c%0d", tag, c), underrun, und_m[c]);
      if (stb_m[c]) begin
        check_eq($sformatf("%s_i_k%0d", tag, k), i_bit, bits[2*k]);
        check_eq($sformatf("%s_q_k%0d", tag, k), q_bit, bits[2*k+1]);
        check_eq($sformatf("%s_act_k%0d", tag, k), sym_active, 1);
        k++;
      end
      if (und_m[c]) begin
        check_eq($sformatf("%s_und_iq_c%0d", tag, c), {i_bit, q_bit}, 0);
        check_eq($sformatf("%s_und_act_c%0d", tag, c), sym_active, 0);
      end
    end
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    flush     = 1'b0;
    sps       = 8'd4;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_i", i_bit, 0);
    check_eq("rst_q", q_bit, 0);
    check_eq("rst_stb", sym_strobe, 0);
    check_eq("rst_act", sym_active, 0);
    check_eq("rst_und", underrun, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // sps=4, dibits (1,0),(1,1): strobes at 3 and 7, underrun at 11
    run_stream("t1_sps4", 8'd4, 4, 16'b1101, 12, 32'h1E, 32'h88, 32'h800, 32'h0);
    // sps=2, continuous 1,0,0,1,1,1,0,0: strobes every 2 cycles
    run_stream("t2_sps2", 8'd2, 8, 16'b0011_1001, 12, 32'h1FE, 32'h2A8, 32'h800, 32'h0);
    // sps=0 and sps=1 behave identically: one-cycle symbol then underrun
    run_stream("t3_sps0", 8'd0, 2, 16'b10, 5, 32'h6, 32'h8, 32'h10, 32'h0);
    run_stream("t3_sps1", 8'd1, 2, 16'b10, 5, 32'h6, 32'h8, 32'h10, 32'h0);
    // pending full plus half I: ready low on cycles 6,7 until the load
    run_stream("t4_bp", 8'd4, 6, 16'b01_1011, 16, 32'h13E, 32'h888, 32'h8000, 32'h0);
    // flush coincides with the load at cycle 7: pair (1,1) still sent,
    // half I bit dropped, so no third symbol and underrun at 11
    run_stream("t5_flush", 8'd4, 6, 16'b01_1101, 12, 32'h13E, 32'h88, 32'h800, 32'h80);

    // reset mid-HOLD with sps=8
    sps       = 8'd8;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    check_eq("t6_pre_stb", sym_strobe, 1);
    check_eq("t6_pre_q", q_bit, 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_pre_act", sym_active, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_iq", {i_bit, q_bit}, 0);
    check_eq("t6_rst_stb", sym_strobe, 0);
    check_eq("t6_rst_act", sym_active, 0);
    check_eq("t6_rst_und", underrun, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b0;
    #1;
    check_eq("t6_rdy_en0", bit_ready, 0);
    enable = 1'b1;
    #1;
    check_eq("t6_rdy_en1", bit_ready, 1);
    @(posedge clk);
    #1;
    check_eq("t6_post_stb", sym_strobe, 0);
    check_eq("t6_post_act", sym_active, 0);
    check_eq("t6_post_und", underrun, 0);
    // collector EMPTY and FSM IDLE: a fresh dibit pairs cleanly
    run_stream("t6_fresh", 8'd1, 2, 16'b10, 5, 32'h6, 32'h8, 32'h10, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule : tb_qpsk_symbol_sequencer
